// File: rtl/arb_pe_wei_rr.sv
// ---------------------------------------------------------------------------
// arb_pe_wei_rr
//   Round-robin arbiter that merges weight-request streams from NUM_REQ PE
//   blocks into one registered, back-pressured stream toward the weight
//   buffer port. A grant may be locked for a burst of cfg_burst beats, and
//   the round-robin pointer wraps correctly for any NUM_REQ (not only powers
//   of two).
//
// Ports
//   clk        clock
//   rst_n      synchronous active-low reset
//   pull_back  synchronous restart: pointer back to 0, burst lock dropped
//   cfg_burst  beats per grant, sampled when a grant starts (0 acts as 1)
//   req_val    per-PE request valid
//   req_data   per-PE request word, PE i at [i*DATA_W +: DATA_W]
//   req_rdy    per-PE accept (combinational, at most one bit high)
//   out_val    registered output valid
//   out_data   registered output word
//   out_idx    source PE of out_data
//   out_last   high on the final beat of a burst
//   out_rdy    downstream accept
// ---------------------------------------------------------------------------
module arb_pe_wei_rr #(
  parameter  int NUM_REQ = 16,
  parameter  int DATA_W  = 8,
  parameter  int BURST_W = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pull_back,
  input  logic [BURST_W-1:0]        cfg_burst,
  input  logic [NUM_REQ-1:0]        req_val,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_rdy,
  output logic                      out_val,
  output logic [DATA_W-1:0]         out_data,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      out_last,
  input  logic                      out_rdy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [BURST_W-1:0] blen_q, blen_d;

  logic               load_en;
  logic [BURST_W-1:0] blen_now;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               xfer;
  logic               xfer_last;
  logic [IDX_W-1:0]   xfer_idx;
  logic [DATA_W-1:0]  xfer_data;

  // Index base+off modulo NUM_REQ. Both operands are already below NUM_REQ,
  // so one conditional subtraction is enough and no out-of-range index can
  // appear even when NUM_REQ is not a power of two.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                 input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Successor of a requester index, wrapping NUM_REQ-1 back to 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(NUM_REQ - 1)) return '0;
    return i + IDX_W'(1);
  endfunction

  assign load_en  = ~out_val | out_rdy;
  assign blen_now = (cfg_burst == '0) ? BURST_W'(1) : cfg_burst;

  // Rotating-priority search: the first asserted request starting at ptr_q
  // and moving upward with wrap-around wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_val[wrap_add(ptr_q, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      blen_q     <= BURST_W'(1);
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      blen_q     <= blen_d;
    end
  end

  // Next-state logic and req_rdy generation. A beat only moves when the
  // output register can take it (load_en), so req_rdy already folds in the
  // downstream back-pressure. In LOCK the owner keeps the grant even while
  // its req_val is low; beats are counted only on actual transfers.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    blen_d     = blen_q;
    req_rdy    = '0;
    xfer       = 1'b0;
    xfer_last  = 1'b0;
    xfer_idx   = '0;

    if (!rst_n) begin
      // Hold everything; the register block applies the reset values.
    end else if (pull_back) begin
      state_d    = IDLE;
      ptr_d      = '0;
      beat_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found && load_en) begin
            req_rdy[win_idx] = 1'b1;
            xfer             = 1'b1;
            xfer_idx         = win_idx;
            blen_d           = blen_now;
            if (blen_now == BURST_W'(1)) begin
              xfer_last = 1'b1;
              ptr_d     = next_idx(win_idx);
            end else begin
              owner_d    = win_idx;
              beat_cnt_d = BURST_W'(1);
              state_d    = LOCK;
            end
          end
        end
        LOCK: begin
          req_rdy[owner_q] = load_en;
          if (load_en && req_val[owner_q]) begin
            xfer     = 1'b1;
            xfer_idx = owner_q;
            if (beat_cnt_q == blen_q - BURST_W'(1)) begin
              xfer_last  = 1'b1;
              ptr_d      = next_idx(owner_q);
              beat_cnt_d = '0;
              state_d    = IDLE;
            end else begin
              beat_cnt_d = beat_cnt_q + BURST_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Select the word of the requester that is transferring this cycle.
  always_comb begin
    xfer_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer_idx == IDX_W'(i)) xfer_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Output register: loads on a transfer, otherwise drains when accepted.
  // pull_back never touches it, so a pending beat still leaves normally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_val  <= 1'b0;
      out_data <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
    end else if (xfer) begin
      out_val  <= 1'b1;
      out_data <= xfer_data;
      out_idx  <= xfer_idx;
      out_last <= xfer_last;
    end else if (out_rdy) begin
      out_val  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_pe_wei_rr.sv
// ---------------------------------------------------------------------------
// tb_arb_pe_wei_rr
//   Directed bench for arb_pe_wei_rr. A 16-requester instance covers the
//   round-robin sweep, bursts, stalls, back-pressure, pull_back and reset; a
//   5-requester instance covers pointer wrap for a non power-of-two count.
//   Inputs change on the falling edge, outputs are sampled on the falling
//   edge (registered) or 1 time unit after it (combinational req_rdy).
// ---------------------------------------------------------------------------
module tb_arb_pe_wei_rr;

  localparam int NR  = 16;
  localparam int DW  = 8;
  localparam int BW  = 4;
  localparam int IW  = 4;
  localparam int NR5 = 5;
  localparam int IW5 = 3;

  logic clk = 1'b0;
  logic rst_n;

  logic            pull_back;
  logic [BW-1:0]   cfg_burst;
  logic [NR-1:0]   req_val;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_rdy;
  logic            out_val;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_idx;
  logic            out_last;
  logic            out_rdy;

  logic             pb5;
  logic [BW-1:0]    cfg5;
  logic [NR5-1:0]   rv5;
  logic [NR5*DW-1:0] rd5;
  logic [NR5-1:0]   rr5;
  logic             ov5;
  logic [DW-1:0]    od5;
  logic [IW5-1:0]   oi5;
  logic             ol5;
  logic             ordy5;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arb_pe_wei_rr #(.NUM_REQ(NR), .DATA_W(DW), .BURST_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .pull_back(pull_back), .cfg_burst(cfg_burst),
    .req_val(req_val), .req_data(req_data), .req_rdy(req_rdy),
    .out_val(out_val), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .out_rdy(out_rdy)
  );

  arb_pe_wei_rr #(.NUM_REQ(NR5), .DATA_W(DW), .BURST_W(BW)) dut5 (
    .clk(clk), .rst_n(rst_n), .pull_back(pb5), .cfg_burst(cfg5),
    .req_val(rv5), .req_data(rd5), .req_rdy(rr5),
    .out_val(ov5), .out_data(od5), .out_idx(oi5),
    .out_last(ol5), .out_rdy(ordy5)
  );

  function automatic logic [DW-1:0] peData(input int i);
    return 8'hA0 + 8'(i);
  endfunction

  function automatic logic [DW-1:0] peData5(input int i);
    return 8'h50 + 8'(i);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Expect a valid beat from the 16-requester instance.
  task automatic checkBeat(input string tag, input int idx, input logic last);
    checkOutput({tag, "_val"},  32'(out_val),  32'd1);
    checkOutput({tag, "_idx"},  32'(out_idx),  32'(idx));
    checkOutput({tag, "_last"}, 32'(out_last), 32'(last));
    checkOutput({tag, "_data"}, 32'(out_data), 32'(peData(idx)));
  endtask

  task automatic checkBeat5(input string tag, input int idx);
    checkOutput({tag, "_val"},  32'(ov5), 32'd1);
    checkOutput({tag, "_idx"},  32'(oi5), 32'(idx));
    checkOutput({tag, "_last"}, 32'(ol5), 32'd1);
    checkOutput({tag, "_data"}, 32'(od5), 32'(peData5(idx)));
  endtask

  task automatic applyStimulus(input logic [NR-1:0] rv, input logic [BW-1:0] cfg,
                               input logic ordy, input logic pb);
    req_val   = rv;
    cfg_burst = cfg;
    out_rdy   = ordy;
    pull_back = pb;
  endtask

  // Two-cycle reset; returns on a falling edge with rst_n released.
  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus('0, 4'd1, 1'b1, 1'b0);
    rv5 = '0; cfg5 = 4'd1; ordy5 = 1'b1; pb5 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < NR; i++)  req_data[i*DW +: DW] = peData(i);
    for (int i = 0; i < NR5; i++) rd5[i*DW +: DW]      = peData5(i);
    rst_n = 1'b0;
    applyStimulus('0, 4'd1, 1'b1, 1'b0);
    rv5 = '0; cfg5 = 4'd1; ordy5 = 1'b1; pb5 = 1'b0;

    // Test 1: reset values, then a full single-beat sweep with wrap.
    @(negedge clk);
    req_val = '1;
    #1 checkOutput("rst_req_rdy", 32'(req_rdy), 32'h0);
    @(negedge clk);
    checkOutput("rst_out_val",  32'(out_val),  32'h0);
    checkOutput("rst_out_data", 32'(out_data), 32'h0);
    checkOutput("rst_out_idx",  32'(out_idx),  32'h0);
    checkOutput("rst_out_last", 32'(out_last), 32'h0);
    checkOutput("rst_out_val5", 32'(ov5),      32'h0);
    rst_n = 1'b1;
    #1 checkOutput("t1_first_rdy", 32'(req_rdy), 32'h0001);
    for (int k = 0; k <= NR; k++) begin
      @(negedge clk);
      checkBeat($sformatf("t1_beat%0d", k), k % NR, 1'b1);
    end
    req_val = '0;

    // Test 2: five requesters, pointer parked at 4, requests on 0 and 4.
    applyReset();
    rv5 = 5'b01000;
    @(negedge clk);
    checkBeat5("t2_park", 3);
    rv5 = 5'b10001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkBeat5($sformatf("t2_g%0d", k), (k % 2 == 0) ? 4 : 0);
    end
    rv5 = '0;

    // Test 3: bursts of 3 on PE 2 then PE 7; cfg_burst changed mid-burst.
    applyReset();
    applyStimulus(16'h0084, 4'd3, 1'b1, 1'b0);
    #1 checkOutput("t3_rdy_grant", 32'(req_rdy), 32'h0004);
    @(negedge clk);
    checkBeat("t3_b0", 2, 1'b0);
    cfg_burst = 4'd1;
    #1 checkOutput("t3_rdy_lock", 32'(req_rdy), 32'h0004);
    @(negedge clk);
    checkBeat("t3_b1", 2, 1'b0);
    @(negedge clk);
    checkBeat("t3_b2", 2, 1'b1);
    cfg_burst = 4'd3;
    #1 checkOutput("t3_rdy_next", 32'(req_rdy), 32'h0080);
    @(negedge clk);
    checkBeat("t3_b3", 7, 1'b0);
    @(negedge clk);
    checkBeat("t3_b4", 7, 1'b0);
    @(negedge clk);
    checkBeat("t3_b5", 7, 1'b1);
    req_val = '0;
    @(negedge clk);
    checkOutput("t3_drained", 32'(out_val), 32'h0);

    // Test 4: owner drops req_val for two cycles while PE 7 waits.
    applyReset();
    applyStimulus(16'h0084, 4'd3, 1'b1, 1'b0);
    @(negedge clk);
    checkBeat("t4_b0", 2, 1'b0);
    req_val = 16'h0080;
    #1 checkOutput("t4_rdy_gap0", 32'(req_rdy), 32'h0004);
    @(negedge clk);
    checkOutput("t4_gap0_val", 32'(out_val), 32'h0);
    #1 checkOutput("t4_rdy_gap1", 32'(req_rdy), 32'h0004);
    @(negedge clk);
    checkOutput("t4_gap1_val", 32'(out_val), 32'h0);
    req_val = 16'h0084;
    @(negedge clk);
    checkBeat("t4_b1", 2, 1'b0);
    @(negedge clk);
    checkBeat("t4_b2", 2, 1'b1);
    @(negedge clk);
    checkBeat("t4_b3", 7, 1'b0);
    req_val = '0;

    // Test 5: four cycles of downstream back-pressure.
    applyReset();
    applyStimulus(16'h0003, 4'd1, 1'b1, 1'b0);
    @(negedge clk);
    checkBeat("t5_b0", 0, 1'b1);
    out_rdy = 1'b0;
    #1 checkOutput("t5_rdy_stall", 32'(req_rdy), 32'h0);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      checkBeat($sformatf("t5_hold%0d", s), 0, 1'b1);
    end
    out_rdy = 1'b1;
    @(negedge clk);
    checkBeat("t5_b1", 1, 1'b1);
    @(negedge clk);
    checkBeat("t5_b2", 0, 1'b1);
    @(negedge clk);
    checkBeat("t5_b3", 1, 1'b1);
    req_val = '0;

    // Test 6: pull_back mid-burst with ptr at 9, then reset mid-burst.
    applyReset();
    applyStimulus(16'h0100, 4'd1, 1'b1, 1'b0);
    @(negedge clk);
    checkBeat("t6_park", 8, 1'b1);
    applyStimulus(16'h0208, 4'd3, 1'b1, 1'b0);
    #1 checkOutput("t6_rdy_ptr9", 32'(req_rdy), 32'h0200);
    @(negedge clk);
    checkBeat("t6_b0", 9, 1'b0);
    pull_back = 1'b1;
    out_rdy   = 1'b0;
    #1 checkOutput("t6_rdy_pull", 32'(req_rdy), 32'h0);
    @(negedge clk);
    checkBeat("t6_pending", 9, 1'b0);
    pull_back = 1'b0;
    out_rdy   = 1'b1;
    #1 checkOutput("t6_rdy_from0", 32'(req_rdy), 32'h0008);
    @(negedge clk);
    checkBeat("t6_b1", 3, 1'b0);
    rst_n = 1'b0;
    #1 checkOutput("t6_rdy_rst", 32'(req_rdy), 32'h0);
    @(negedge clk);
    checkOutput("t6_rst_val",  32'(out_val),  32'h0);
    checkOutput("t6_rst_data", 32'(out_data), 32'h0);
    checkOutput("t6_rst_idx",  32'(out_idx),  32'h0);
    checkOutput("t6_rst_last", 32'(out_last), 32'h0);
    rst_n     = 1'b1;
    cfg_burst = 4'd1;
    #1 checkOutput("t6_rdy_after", 32'(req_rdy), 32'h0008);
    @(negedge clk);
    checkBeat("t6_after", 3, 1'b1);
    req_val = '0;

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
